// File: rtl/operand_join_buffer_join_fifo.sv
// One side of the operand join: a circular FIFO with an occupancy level.
// A push into a full FIFO is accepted only when a pop frees a slot on the same edge.
module join_fifo #(
    parameter int N = 16,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          push,
    input  logic [N-1:0]  din,
    input  logic          pop,
    output logic [N-1:0]  head,
    output logic [AW:0]   level,
    output logic          full,
    output logic          drop
);

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          accept;

    assign full   = (level == (AW+1)'(DEPTH));
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;
    assign head   = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (!RST && accept) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (accept && !pop) begin
                level <= level + (AW+1)'(1);
            end else if (pop && !accept) begin
                level <= level - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/operand_join_buffer.sv
// Buffers two independently timed operand streams and re-emits them as
// cycle-aligned pairs for two-operand dataflow operators.
module operand_join_buffer #(
    parameter int N = 16,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          EN,
    input  logic          R_IN1,
    input  logic [N-1:0]  D_IN1,
    input  logic          R_IN2,
    input  logic [N-1:0]  D_IN2,
    output logic          R_OUT1,
    output logic [N-1:0]  D_OUT1,
    output logic          R_OUT2,
    output logic [N-1:0]  D_OUT2,
    output logic [AW:0]   LEVEL1,
    output logic [AW:0]   LEVEL2,
    output logic          FULL1,
    output logic          FULL2,
    output logic          OVF
);

    logic         pop;
    logic         drop1;
    logic         drop2;
    logic [N-1:0] head1;
    logic [N-1:0] head2;
    logic         out_valid;

    // Both heads leave together, so a pop needs an operand waiting on each side.
    assign pop = EN && (LEVEL1 != '0) && (LEVEL2 != '0);

    join_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo1 (
        .CLK   (CLK),
        .RST   (RST),
        .push  (R_IN1),
        .din   (D_IN1),
        .pop   (pop),
        .head  (head1),
        .level (LEVEL1),
        .full  (FULL1),
        .drop  (drop1)
    );

    join_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo2 (
        .CLK   (CLK),
        .RST   (RST),
        .push  (R_IN2),
        .din   (D_IN2),
        .pop   (pop),
        .head  (head2),
        .level (LEVEL2),
        .full  (FULL2),
        .drop  (drop2)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid <= 1'b0;
            D_OUT1    <= '0;
            D_OUT2    <= '0;
            OVF       <= 1'b0;
        end else begin
            // EN low stalls the output registers; pushes still proceed.
            if (EN) begin
                out_valid <= pop;
                if (pop) begin
                    D_OUT1 <= head1;
                    D_OUT2 <= head2;
                end
            end
            if (drop1 || drop2) begin
                OVF <= 1'b1;
            end
        end
    end

    assign R_OUT1 = out_valid;
    assign R_OUT2 = out_valid;

endmodule
